// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler with memory-wait FSM and perf counters
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic [4:0]       x_rd,
  input  logic             x_is_load,
  input  logic             x_branch_taken,
  input  logic             m_mem_req,
  input  logic             dmem_ready,
  output logic             f_stall,
  output logic             d_stall,
  output logic             x_stall,
  output logic             m_stall,
  output logic             d_flush,
  output logic             x_flush,
  output logic             mw_bubble,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  // Wait counter value during the final allowed stall cycle; that cycle's edge enters FAULT.
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_next;
  logic       mem_stall;
  logic       load_use;
  logic       any_stall;
  logic       any_flush;

  assign mem_stall = (state != FAULT) && m_mem_req && !dmem_ready;
  // x0 is hardwired zero, so a load targeting it can never create a dependency.
  assign load_use  = x_is_load && (x_rd != 5'd0) &&
                     ((d_uses_rs1 && (d_rs1 == x_rd)) || (d_uses_rs2 && (d_rs2 == x_rd)));
  assign any_stall = f_stall | d_stall | x_stall | m_stall;
  assign any_flush = d_flush | x_flush;

  // Prioritised pipeline controls: fault, memory wait, taken branch, load-use.
  always_comb begin
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    x_stall   = 1'b0;
    m_stall   = 1'b0;
    d_flush   = 1'b0;
    x_flush   = 1'b0;
    mw_bubble = 1'b0;
    bus_error = 1'b0;
    if (state == FAULT) begin
      f_stall   = 1'b1;
      d_stall   = 1'b1;
      x_stall   = 1'b1;
      m_stall   = 1'b1;
      mw_bubble = 1'b1;
      bus_error = 1'b1;
    end else if (mem_stall) begin
      f_stall   = 1'b1;
      d_stall   = 1'b1;
      x_stall   = 1'b1;
      m_stall   = 1'b1;
      mw_bubble = 1'b1;
    end else if (x_branch_taken) begin
      // Decode holds a wrong-path instruction, so the branch wins over load-use.
      d_flush = 1'b1;
      x_flush = 1'b1;
    end else if (load_use) begin
      f_stall = 1'b1;
      d_stall = 1'b1;
      x_flush = 1'b1;
    end
  end

  // Memory-wait FSM next state and wait-counter update.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next = MEM_WAIT;
          wait_next  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_next = RUN;
          wait_next  = 8'd0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = FAULT;
        end else begin
          wait_next = wait_cnt + 8'd1;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = RUN;
        wait_next  = 8'd0;
      end
    endcase
  end

  // FSM state and wait-counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Saturating performance counters, one event per cycle each.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (any_stall && (stall_count != CNT_MAX)) stall_count <= stall_count + 1'b1;
      if (any_flush && (flush_count != CNT_MAX)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] d_rs1, d_rs2, x_rd;
  logic       d_uses_rs1, d_uses_rs2, x_is_load, x_branch_taken, m_mem_req, dmem_ready;

  logic        fs_a, ds_a, xs_a, ms_a, df_a, xf_a, mb_a, be_a;
  logic        fs_b, ds_b, xs_b, ms_b, df_b, xf_b, mb_b, be_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  logic [7:0]  ctrl_a, ctrl_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per instance: index 0 = dut_a, index 1 = dut_b.
  int tmo  [2] = '{4, 255};
  int cmax [2] = '{65535, 15};
  int run_len [2];
  bit in_fault [2];
  int scnt [2];
  int fcnt [2];

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2), .x_rd(x_rd),
    .x_is_load(x_is_load), .x_branch_taken(x_branch_taken),
    .m_mem_req(m_mem_req), .dmem_ready(dmem_ready),
    .f_stall(fs_a), .d_stall(ds_a), .x_stall(xs_a), .m_stall(ms_a),
    .d_flush(df_a), .x_flush(xf_a), .mw_bubble(mb_a), .bus_error(be_a),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(255), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2), .x_rd(x_rd),
    .x_is_load(x_is_load), .x_branch_taken(x_branch_taken),
    .m_mem_req(m_mem_req), .dmem_ready(dmem_ready),
    .f_stall(fs_b), .d_stall(ds_b), .x_stall(xs_b), .m_stall(ms_b),
    .d_flush(df_b), .x_flush(xf_b), .mw_bubble(mb_b), .bus_error(be_b),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  assign ctrl_a = {fs_a, ds_a, xs_a, ms_a, df_a, xf_a, mb_a, be_a};
  assign ctrl_b = {fs_b, ds_b, xs_b, ms_b, df_b, xf_b, mb_b, be_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control vector {f,d,x,m stall, d_flush, x_flush, mw_bubble, bus_error} from the priority rules.
  function automatic logic [7:0] model_ctrl(input bit flt);
    bit lu;
    if (flt) return 8'b1111_0011;
    if (m_mem_req && !dmem_ready) return 8'b1111_0010;
    if (x_branch_taken) return 8'b0000_1100;
    lu = x_is_load && (x_rd != 0) &&
         ((d_uses_rs1 && d_rs1 == x_rd) || (d_uses_rs2 && d_rs2 == x_rd));
    if (lu) return 8'b1100_0100;
    return 8'b0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      run_len[i] = 0; in_fault[i] = 1'b0; scnt[i] = 0; fcnt[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      e = model_ctrl(in_fault[i]);
      if (|e[7:4] && scnt[i] < cmax[i]) scnt[i]++;
      if (|e[3:2] && fcnt[i] < cmax[i]) fcnt[i]++;
      if (!in_fault[i]) begin
        if (m_mem_req && !dmem_ready) begin
          run_len[i]++;
          if (run_len[i] == tmo[i]) in_fault[i] = 1'b1;
        end else begin
          run_len[i] = 0;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".ctrl_a"}, 32'(ctrl_a), 32'(model_ctrl(in_fault[0])));
    check({tag, ".ctrl_b"}, 32'(ctrl_b), 32'(model_ctrl(in_fault[1])));
    check({tag, ".sc_a"}, 32'(sc_a), 32'(scnt[0]));
    check({tag, ".fc_a"}, 32'(fc_a), 32'(fcnt[0]));
    check({tag, ".sc_b"}, 32'(sc_b), 32'(scnt[1]));
    check({tag, ".fc_b"}, 32'(fc_b), 32'(fcnt[1]));
  endtask

  task automatic idle();
    d_rs1 = 0; d_rs2 = 0; d_uses_rs1 = 0; d_uses_rs2 = 0; x_rd = 0;
    x_is_load = 0; x_branch_taken = 0; m_mem_req = 0; dmem_ready = 0;
  endtask

  // Inputs are already driven; check mid-cycle, then let the edge happen.
  task automatic cycle(input string tag);
    @(negedge clock);
    check_all(tag);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse between edges; outputs must drop without waiting for a clock.
  task automatic async_reset(input string tag);
    idle();
    reset = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle();
    model_clear();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Load-use on rs2: one bubble.
    x_is_load = 1; x_rd = 5; d_rs2 = 5; d_uses_rs2 = 1;
    cycle("lu");
    idle();
    cycle("lu_after");
    check("lu_scnt", 32'(sc_a), 32'd1);
    check("lu_fcnt", 32'(fc_a), 32'd1);

    // Load into x0 never hazards.
    x_is_load = 1; x_rd = 0; d_rs2 = 0; d_uses_rs2 = 1;
    cycle("lu_x0");
    check("lu_x0_scnt", 32'(sc_a), 32'd1);

    // Taken branch beats load-use.
    x_is_load = 1; x_rd = 7; d_rs1 = 7; d_uses_rs1 = 1; x_branch_taken = 1;
    @(negedge clock);
    check("br_ctrl", 32'(ctrl_a), 32'h0C);
    @(posedge clock); model_edge(); #1;
    idle();
    cycle("br_after");
    check("br_fcnt", 32'(fc_a), 32'd2);

    // Memory wait of 3 cycles with a simultaneous branch (stall wins).
    m_mem_req = 1; x_branch_taken = 1;
    repeat (3) cycle("mw");
    dmem_ready = 1;
    cycle("mw_done");
    idle();
    cycle("mw_idle");
    check("mw_scnt", 32'(sc_a), 32'd4);

    // Timeout on dut_a (MEM_TIMEOUT=4), keep holding for dut_b saturation.
    m_mem_req = 1;
    for (int i = 0; i < 20; i++) cycle("tmo");
    check("tmo_bus_a", 32'(be_a), 32'd1);
    check("tmo_bus_b", 32'(be_b), 32'd0);
    check("sat_scnt_b", 32'(sc_b), 32'd15);
    dmem_ready = 1;
    repeat (2) cycle("fault_hold");
    idle();
    cycle("fault_idle");
    async_reset("rst_fault");
    cycle("post_rst");

    // Reset in the middle of a memory wait.
    m_mem_req = 1;
    repeat (2) cycle("mw2");
    async_reset("rst_mw");
    cycle("post_rst2");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
      d_rs1          = 5'($urandom_range(0, 3));
      d_rs2          = 5'($urandom_range(0, 3));
      x_rd           = 5'($urandom_range(0, 3));
      d_uses_rs1     = 1'($urandom_range(0, 1));
      d_uses_rs2     = 1'($urandom_range(0, 1));
      x_is_load      = ($urandom_range(0, 99) < 50);
      x_branch_taken = ($urandom_range(0, 99) < 15);
      m_mem_req      = ($urandom_range(0, 99) < 35);
      dmem_ready     = ($urandom_range(0, 99) < 55);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the five-stage pipeline. It watches decode operands, the execute-stage destination, branch redirects and the data-memory handshake. Each cycle it drives the hold and bubble controls of the F/D, D/X, X/M and M/W pipeline registers. It also runs a small memory-wait FSM with timeout and keeps saturating performance counters.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-wait cycles before entering FAULT (legal range 2..255).
- CNT_W, 16: width of the performance counters.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- d_rs1, d_rs2  in  5 each  source registers of the instruction in decode
- d_uses_rs1, d_uses_rs2  in  1 each  decode instruction reads rs1 / rs2
- x_rd  in  5  destination register in execute
- x_is_load  in  1  execute instruction is a load
- x_branch_taken  in  1  execute resolved a taken branch or jump
- m_mem_req  in  1  memory stage is issuing a data access
- dmem_ready  in  1  data memory completes the access this cycle
- f_stall, d_stall, x_stall, m_stall  out  1 each  hold the PC, F/D, D/X and X/M registers
- d_flush, x_flush  out  1 each  load a bubble into F/D or D/X this edge
- mw_bubble  out  1  force w_reg_write_enabled = 0 into M/W this edge
- bus_error  out  1  sticky memory-timeout flag
- stall_count, flush_count  out  CNT_W each  saturating counters

## Operation
- Stall/flush outputs are combinational from inputs and FSM state. Counters, FSM state and the wait counter are registered.
- FSM states:
  - RUN
  - MEM_WAIT
  - FAULT
- mem_stall = m_mem_req && !dmem_ready, evaluated in RUN or MEM_WAIT.
- Priority, highest first:
  - FAULT: f/d/x/m_stall = 1, mw_bubble = 1, d_flush = x_flush = 0, bus_error = 1.
  - mem_stall: f/d/x/m_stall = 1, mw_bubble = 1. Branch and load-use actions are suppressed. Execute re-presents them after the wait.
  - x_branch_taken: d_flush = 1, x_flush = 1, no stalls. Branch beats load-use because decode is wrong-path.
  - load_use = x_is_load && x_rd != 0 && ((d_uses_rs1 && d_rs1 == x_rd) || (d_uses_rs2 && d_rs2 == x_rd)).
    - On load_use: f_stall = d_stall = 1, x_flush = 1. X/M and M/W advance.
  - Otherwise all outputs are 0.
- Register x0 never causes a hazard.
- FSM transitions:
  - RUN → MEM_WAIT on mem_stall. The wait counter is set to 1.
  - MEM_WAIT → RUN when !mem_stall. This covers both dmem_ready = 1 and a dropped m_mem_req. The wait counter clears.
  - MEM_WAIT → FAULT at the edge ending the MEM_TIMEOUT-th consecutive mem_stall cycle. Otherwise the wait counter increments.
  - FAULT is terminal until reset.
- stall_count increments once per cycle when any of f/d/x/m_stall is 1.
- flush_count increments once per cycle when d_flush or x_flush is 1.
- Both counters saturate at all-ones and never wrap.
- Reset values:
  - state = RUN, wait counter = 0, both counters = 0, bus_error = 0.
  - With inputs idle, every combinational output reads 0.

## Timing
- Zero-cycle decision: the controls are valid in the same cycle as the causing inputs and act at the next rising edge.
- Load-use costs exactly 1 bubble: the stall lasts one cycle because x_is_load has moved to M at the next edge.
- A taken branch costs 2 bubbles (F/D and D/X) in one cycle.
- Memory wait of k cycles (dmem_ready low for k cycles, then high):
  - k stall cycles, k ≤ MEM_TIMEOUT − 1.
  - The pipeline advances on the edge where dmem_ready = 1.
- Ready in the request's first cycle gives zero stall and no MEM_WAIT entry.
- Reset asserted mid-MEM_WAIT or in FAULT:
  - Immediate asynchronous return to RUN, with counters and bus_error cleared.
  - The outputs drop in the same cycle.
- Simultaneous mem_stall and x_branch_taken: only the stall acts. The flush occurs in the cycle dmem_ready rises, if the branch is still in X.

## Test plan
- Load-use: x_is_load = 1, x_rd = 5, d_rs2 = 5, d_uses_rs2 = 1.
  - Expect f_stall = d_stall = x_flush = 1 for one cycle.
  - Expect stall_count = 1 and flush_count = 1.
  - Repeat with x_rd = 0: expect no action.
- Taken branch together with a load-use match: expect d_flush = x_flush = 1, f_stall = 0, and flush_count +1.
- Memory wait: m_mem_req = 1, dmem_ready low for 3 cycles, then high.
  - Expect f/d/x/m_stall = mw_bubble = 1 for exactly 3 cycles.
  - Expect state back in RUN and stall_count = 3.
- Timeout, MEM_TIMEOUT = 4, dmem_ready held low:
  - Expect FAULT after the 4th stalled edge, bus_error = 1, and all stalls held.
  - Later dmem_ready = 1 does not clear it; reset clears everything.
- Counter saturation, CNT_W = 4: hold mem_stall for 20 cycles with MEM_TIMEOUT = 255. Expect stall_count = 15, with no wrap.
- Reset mid-MEM_WAIT: expect outputs at 0 immediately and counters at 0.
